instr_fetch_seq: RTL and testbench

INSTR_FETCH_SEQ -- requirements
Module: instr_fetch_seq

---
 rtl/arch_defs_pkg.sv | 21 ++
 rtl/program_counter.sv | 28 ++
 rtl/instr_fetch_seq.sv | 121 ++++++++++++
 tb/tb_instr_fetch_seq.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arch_defs_pkg.sv
// Shared definitions for the instruction fetch block: FSM state encoding
// and the default reset vector.
package arch_defs_pkg;

  // Address the fetcher starts from after reset unless overridden.
  localparam logic [15:0] DEFAULT_RESET_VECTOR = 16'hF000;

  // Fetch sequencer states.
  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    FETCH_OP   = 2'd1,
    FETCH_OPND = 2'd2,
    DONE       = 2'd3
  } fetch_state_t;

  // True in the states that own the memory read port.
  function automatic logic is_fetch(input fetch_state_t s);
    return (s == FETCH_OP) || (s == FETCH_OPND);
  endfunction

endpackage

// File: rtl/program_counter.sv
// Program counter: synchronous load (jump) with priority over increment.
// Increment wraps naturally modulo 2^ADDR_WIDTH.
module program_counter
  import arch_defs_pkg::*;
#(
  parameter int                    ADDR_WIDTH   = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = ADDR_WIDTH'(DEFAULT_RESET_VECTOR)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  load,
  input  logic [ADDR_WIDTH-1:0] load_val,
  input  logic                  inc,
  output logic [ADDR_WIDTH-1:0] pc
);

  // PC register: reset vector, then load beats increment.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc <= RESET_VECTOR;
    end else if (load) begin
      pc <= load_val;
    end else if (inc) begin
      pc <= pc + ADDR_WIDTH'(1);
    end
  end

endmodule

// File: rtl/instr_fetch_seq.sv
// Instruction fetch sequencer: reads an opcode byte, asks the decoder how
// many operand bytes follow, reads those into a little-endian operand word,
// then presents the complete instruction to the consumer.
//
// Handshakes:
//   memory   - mem_req_o/mem_addr_o are held stable while mem_req_o is high;
//              a byte transfers on a rising edge where mem_req_o and mem_ack_i
//              are both 1. mem_ack_i is ignored while mem_req_o is 0.
//   consumer - instr_valid_o/opcode_o/operand_o are held stable while
//              instr_valid_o is high; the instruction transfers on a rising
//              edge where instr_valid_o and instr_ready_i are both 1.
module instr_fetch_seq
  import arch_defs_pkg::*;
#(
  parameter int                    ADDR_WIDTH     = 16,
  parameter int                    DATA_WIDTH     = 8,
  parameter int                    MAX_OPND_BYTES = 2,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR   = ADDR_WIDTH'(DEFAULT_RESET_VECTOR),
  localparam int                   OPND_WIDTH     = DATA_WIDTH * MAX_OPND_BYTES,
  localparam int                   CNT_WIDTH      = $clog2(MAX_OPND_BYTES + 1)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start_i,
  input  logic                  halt_i,
  input  logic                  pc_load_i,
  input  logic [ADDR_WIDTH-1:0] pc_load_val_i,
  output logic                  mem_req_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  input  logic                  mem_ack_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  input  logic [CNT_WIDTH-1:0]  opnd_cnt_i,
  output logic [DATA_WIDTH-1:0] opcode_o,
  output logic [OPND_WIDTH-1:0] operand_o,
  output logic [ADDR_WIDTH-1:0] pc_o,
  output logic                  instr_valid_o,
  input  logic                  instr_ready_i,
  output logic                  busy_o,
  output fetch_state_t          dbg_state_o
);

  localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(MAX_OPND_BYTES);

  fetch_state_t         state;
  logic [CNT_WIDTH-1:0] idx;
  logic [CNT_WIDTH-1:0] count;
  logic [CNT_WIDTH-1:0] idx_nxt;
  logic [CNT_WIDTH-1:0] cnt_clamped;
  logic                 mem_fire;
  logic                 pc_load_en;

  // Status outputs decode straight from the state register, so they can
  // only change on a clock edge (or reset) and never glitch.
  assign mem_req_o     = is_fetch(state);
  assign mem_addr_o    = pc_o;
  assign instr_valid_o = (state == DONE);
  assign busy_o        = (state != IDLE);
  assign dbg_state_o   = state;

  // A byte is consumed only when the request is actually outstanding.
  assign mem_fire = mem_req_o & mem_ack_i;

  // Jumps are accepted only while no fetch is in progress.
  assign pc_load_en = pc_load_i & ((state == IDLE) || (state == DONE));

  // Decoder may report more bytes than the operand register holds; clamp.
  assign cnt_clamped = (opnd_cnt_i > MAX_CNT) ? MAX_CNT : opnd_cnt_i;
  assign idx_nxt     = idx + CNT_WIDTH'(1);

  program_counter #(
    .ADDR_WIDTH   (ADDR_WIDTH),
    .RESET_VECTOR (RESET_VECTOR)
  ) u_pc (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (pc_load_en),
    .load_val (pc_load_val_i),
    .inc      (mem_fire),
    .pc       (pc_o)
  );

  // Fetch FSM with the opcode/operand capture registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      opcode_o  <= '0;
      operand_o <= '0;
      idx       <= '0;
      count     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i && !halt_i) state <= FETCH_OP;
        end
        FETCH_OP: begin
          if (mem_ack_i) begin
            opcode_o  <= mem_rdata_i;
            operand_o <= '0;
            idx       <= '0;
            count     <= cnt_clamped;
            state     <= (cnt_clamped == '0) ? DONE : FETCH_OPND;
          end
        end
        FETCH_OPND: begin
          if (mem_ack_i) begin
            for (int b = 0; b < MAX_OPND_BYTES; b++) begin
              if (idx == CNT_WIDTH'(b)) operand_o[b*DATA_WIDTH +: DATA_WIDTH] <= mem_rdata_i;
            end
            idx <= idx_nxt;
            if (idx_nxt == count) state <= DONE;
          end
        end
        DONE: begin
          if (instr_ready_i) state <= halt_i ? IDLE : FETCH_OP;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_seq.sv
// Testbench for instr_fetch_seq: byte memory + decoder count table model,
// directed scenarios and randomized single-instruction fetches.
module tb_instr_fetch_seq;
  import arch_defs_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start_i, halt_i, pc_load_i;
  logic [15:0] pc_load_val_i;
  logic        mem_req_o;
  logic [15:0] mem_addr_o;
  logic        mem_ack_i;
  logic [7:0]  mem_rdata_i;
  logic [1:0]  opnd_cnt_i;
  logic [7:0]  opcode_o;
  logic [15:0] operand_o;
  logic [15:0] pc_o;
  logic        instr_valid_o, instr_ready_i, busy_o;
  fetch_state_t dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  // Memory image, decoder operand-count table, responder configuration.
  logic [7:0] mem     [0:65535];
  logic [1:0] cnt_tab [0:255];
  int         wait_cycles = 0;
  bit         spurious = 1'b0;
  int         wcnt = 0;

  always #5 clk = ~clk;

  instr_fetch_seq dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .start_i       (start_i),
    .halt_i        (halt_i),
    .pc_load_i     (pc_load_i),
    .pc_load_val_i (pc_load_val_i),
    .mem_req_o     (mem_req_o),
    .mem_addr_o    (mem_addr_o),
    .mem_ack_i     (mem_ack_i),
    .mem_rdata_i   (mem_rdata_i),
    .opnd_cnt_i    (opnd_cnt_i),
    .opcode_o      (opcode_o),
    .operand_o     (operand_o),
    .pc_o          (pc_o),
    .instr_valid_o (instr_valid_o),
    .instr_ready_i (instr_ready_i),
    .busy_o        (busy_o),
    .dbg_state_o   (dbg_state)
  );

  // Memory/decoder responder: acks after wait_cycles low-phase samples of a
  // pending request; garbage on data/count whenever no ack is given.
  always @(negedge clk) begin
    if (!mem_req_o) begin
      mem_ack_i   = spurious;
      mem_rdata_i = 8'($urandom);
      opnd_cnt_i  = 2'($urandom);
      wcnt        = 0;
    end else if (wcnt == wait_cycles) begin
      mem_ack_i   = 1'b1;
      mem_rdata_i = mem[mem_addr_o];
      opnd_cnt_i  = cnt_tab[mem_rdata_i];
      wcnt        = 0;
    end else begin
      mem_ack_i   = 1'b0;
      mem_rdata_i = 8'($urandom);
      opnd_cnt_i  = 2'($urandom);
      wcnt        = wcnt + 1;
    end
  end

  // Reference: what one instruction fetched at pc0 must look like.
  task automatic model(input logic [15:0] pc0, output logic [7:0] op,
                       output logic [15:0] opnd, output logic [15:0] pc_end, output int n);
    logic [15:0] a;
    op   = mem[pc0];
    n    = int'(cnt_tab[op]);
    if (n > 2) n = 2;
    opnd = 16'h0000;
    for (int k = 0; k < n; k++) begin
      a = pc0 + 16'(k + 1);
      opnd[8*k +: 8] = mem[a];
    end
    pc_end = pc0 + 16'(n + 1);
  endtask

  // Wait for instr_valid_o; cyc = rising edges since call, -1 on timeout.
  // After the first edge start is dropped and halt set to halt_val; with
  // noise, random jump requests are driven while the fetch is running.
  task automatic wait_valid(input bit halt_val, input bit noise, output int cyc);
    cyc = -1;
    for (int i = 1; i <= 200; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (i == 1) begin
        start_i = 1'b0;
        halt_i  = halt_val;
      end
      if (instr_valid_o) begin
        pc_load_i = 1'b0;
        cyc = i;
        break;
      end
      if (noise) begin
        pc_load_i     = 1'($urandom);
        pc_load_val_i = 16'($urandom);
      end
    end
    pc_load_i = 1'b0;
  endtask

  // From IDLE: jump to pc0 then raise start.
  task automatic launch(input logic [15:0] pc0);
    pc_load_i     = 1'b1;
    pc_load_val_i = pc0;
    @(negedge clk);
    pc_load_i = 1'b0;
    start_i   = 1'b1;
  endtask

  // Let a halted, accepted instruction return the FSM to IDLE.
  task automatic finish_instr();
    @(negedge clk);
    halt_i = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start_i = 0; halt_i = 0; pc_load_i = 0; pc_load_val_i = 0; instr_ready_i = 1;
    repeat (3) @(negedge clk);
    n_checks++; if (pc_o !== 16'hF000) begin n_fail++; $display("FAIL reset_pc: got %h expected f000", pc_o); end
    n_checks++; if (instr_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", instr_valid_o); end
    n_checks++; if (mem_req_o !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b expected 0", mem_req_o); end
    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
    n_checks++; if (opcode_o !== 8'h00) begin n_fail++; $display("FAIL reset_opcode: got %h expected 00", opcode_o); end
    n_checks++; if (operand_o !== 16'h0000) begin n_fail++; $display("FAIL reset_operand: got %h expected 0000", operand_o); end
    n_checks++; if (dbg_state !== IDLE) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", dbg_state); end
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if (busy_o !== 1'b0 || pc_o !== 16'hF000) begin n_fail++; $display("FAIL idle_hold: busy %b pc %h expected 0 f000", busy_o, pc_o); end
  endtask

  task automatic test_basic();
    int cyc;
    mem[16'hF000] = 8'h3A; mem[16'hF001] = 8'h33; mem[16'hF002] = 8'h76;
    cnt_tab[8'h3A] = 2'd1; cnt_tab[8'h76] = 2'd0;
    wait_cycles = 0; instr_ready_i = 1'b1;
    start_i = 1'b1;
    wait_valid(1'b0, 1'b0, cyc);
    n_checks++; if (cyc !== 3) begin n_fail++; $display("FAIL basic_lat1: got %0d expected 3", cyc); end
    n_checks++; if (opcode_o !== 8'h3A) begin n_fail++; $display("FAIL basic_op1: got %h expected 3a", opcode_o); end
    n_checks++; if (operand_o !== 16'h0033) begin n_fail++; $display("FAIL basic_opnd1: got %h expected 0033", operand_o); end
    n_checks++; if (pc_o !== 16'hF002) begin n_fail++; $display("FAIL basic_pc1: got %h expected f002", pc_o); end
    wait_valid(1'b1, 1'b0, cyc);
    n_checks++; if (cyc !== 2) begin n_fail++; $display("FAIL b2b_lat: got %0d expected 2", cyc); end
    n_checks++; if (opcode_o !== 8'h76) begin n_fail++; $display("FAIL b2b_op: got %h expected 76", opcode_o); end
    n_checks++; if (operand_o !== 16'h0000) begin n_fail++; $display("FAIL b2b_opnd: got %h expected 0000", operand_o); end
    n_checks++; if (pc_o !== 16'hF003) begin n_fail++; $display("FAIL b2b_pc: got %h expected f003", pc_o); end
    finish_instr();
    n_checks++; if (busy_o !== 1'b0 || instr_valid_o !== 1'b0) begin n_fail++; $display("FAIL halt_idle: busy %b valid %b expected 0 0", busy_o, instr_valid_o); end
  endtask

  task automatic test_wait_states();
    int cyc0, cyc2;
    mem[16'hF000] = 8'hC3; mem[16'hF001] = 8'h34; mem[16'hF002] = 8'h12;
    cnt_tab[8'hC3] = 2'd2;
    wait_cycles = 0;
    launch(16'hF000);
    wait_valid(1'b1, 1'b0, cyc0);
    n_checks++; if (cyc0 !== 4) begin n_fail++; $display("FAIL ws0_lat: got %0d expected 4", cyc0); end
    n_checks++; if (operand_o !== 16'h1234) begin n_fail++; $display("FAIL ws0_opnd: got %h expected 1234", operand_o); end
    n_checks++; if (pc_o !== 16'hF003) begin n_fail++; $display("FAIL ws0_pc: got %h expected f003", pc_o); end
    finish_instr();
    wait_cycles = 2;
    launch(16'hF000);
    wait_valid(1'b1, 1'b0, cyc2);
    n_checks++; if (cyc2 !== cyc0 + 6) begin n_fail++; $display("FAIL ws2_lat: got %0d expected %0d", cyc2, cyc0 + 6); end
    n_checks++; if (opcode_o !== 8'hC3 || operand_o !== 16'h1234) begin n_fail++; $display("FAIL ws2_data: got %h %h expected c3 1234", opcode_o, operand_o); end
    finish_instr();
    wait_cycles = 0;
  endtask

  task automatic test_stall();
    int cyc;
    mem[16'hF020] = 8'h3A; mem[16'hF021] = 8'h5A;
    cnt_tab[8'h3A] = 2'd1;
    instr_ready_i = 1'b0;
    launch(16'hF020);
    wait_valid(1'b1, 1'b0, cyc);
    spurious = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if (instr_valid_o !== 1'b1 || mem_req_o !== 1'b0 || opcode_o !== 8'h3A ||
          operand_o !== 16'h005A || pc_o !== 16'hF022) begin
        n_fail++;
        $display("FAIL stall_hold: valid %b req %b op %h opnd %h pc %h expected 1 0 3a 005a f022",
                 instr_valid_o, mem_req_o, opcode_o, operand_o, pc_o);
      end
    end
    spurious = 1'b0;
    instr_ready_i = 1'b1;
    finish_instr();
    n_checks++; if (instr_valid_o !== 1'b0 || busy_o !== 1'b0 || pc_o !== 16'hF022) begin n_fail++; $display("FAIL stall_release: valid %b busy %b pc %h expected 0 0 f022", instr_valid_o, busy_o, pc_o); end
  endtask

  task automatic test_wrap();
    int cyc;
    mem[16'hFFFF] = 8'h3A; mem[16'h0000] = 8'h55;
    cnt_tab[8'h3A] = 2'd1;
    launch(16'hFFFF);
    wait_valid(1'b1, 1'b0, cyc);
    n_checks++; if (operand_o !== 16'h0055) begin n_fail++; $display("FAIL wrap_opnd: got %h expected 0055", operand_o); end
    n_checks++; if (pc_o !== 16'h0001) begin n_fail++; $display("FAIL wrap_pc: got %h expected 0001", pc_o); end
    finish_instr();
  endtask

  task automatic test_reset_midfetch();
    int cyc;
    bit seen;
    mem[16'hF000] = 8'hC3; mem[16'hF001] = 8'h34; mem[16'hF002] = 8'h12;
    cnt_tab[8'hC3] = 2'd2;
    wait_cycles = 3;
    launch(16'hF000);
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      start_i = 1'b0;
      halt_i  = 1'b1;
      if (mem_req_o && mem_addr_o == 16'hF001) begin seen = 1'b1; break; end
    end
    n_checks++; if (seen !== 1'b1) begin n_fail++; $display("FAIL midfetch_reach: got %b expected 1", seen); end
    #2 reset_n = 1'b0;
    #1;
    n_checks++; if (pc_o !== 16'hF000 || instr_valid_o !== 1'b0 || busy_o !== 1'b0 || mem_req_o !== 1'b0) begin
      n_fail++; $display("FAIL midfetch_reset: pc %h valid %b busy %b req %b expected f000 0 0 0", pc_o, instr_valid_o, busy_o, mem_req_o);
    end
    @(negedge clk);
    reset_n = 1'b1; halt_i = 1'b0; wait_cycles = 0;
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (instr_valid_o || busy_o) seen = 1'b1;
    end
    n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL midfetch_quiet: got %b expected 0", seen); end
    start_i = 1'b1;
    wait_valid(1'b1, 1'b0, cyc);
    n_checks++; if (cyc !== 4 || opcode_o !== 8'hC3 || operand_o !== 16'h1234 || pc_o !== 16'hF003) begin
      n_fail++; $display("FAIL midfetch_refetch: lat %0d op %h opnd %h pc %h expected 4 c3 1234 f003", cyc, opcode_o, operand_o, pc_o);
    end
    finish_instr();
  endtask

  task automatic test_overflow_cnt();
    int cyc;
    mem[16'hF010] = 8'hDD; mem[16'hF011] = 8'h11; mem[16'hF012] = 8'h22; mem[16'hF013] = 8'h33;
    cnt_tab[8'hDD] = 2'd3;
    launch(16'hF010);
    wait_valid(1'b1, 1'b0, cyc);
    n_checks++; if (cyc !== 4) begin n_fail++; $display("FAIL ovf_lat: got %0d expected 4", cyc); end
    n_checks++; if (operand_o !== 16'h2211) begin n_fail++; $display("FAIL ovf_opnd: got %h expected 2211", operand_o); end
    n_checks++; if (pc_o !== 16'hF013) begin n_fail++; $display("FAIL ovf_pc: got %h expected f013", pc_o); end
    finish_instr();
  endtask

  task automatic test_random();
    logic [15:0] pc0, a, e_opnd, e_pc;
    logic [7:0]  op, e_op;
    int          n, cyc, e_lat;
    for (int t = 0; t < 25; t++) begin
      pc0 = 16'($urandom);
      op  = 8'($urandom);
      cnt_tab[op] = 2'($urandom_range(0, 3));
      mem[pc0] = op;
      for (int k = 1; k <= 2; k++) begin
        a = pc0 + 16'(k);
        mem[a] = 8'($urandom);
      end
      wait_cycles = $urandom_range(0, 3);
      model(pc0, e_op, e_opnd, e_pc, n);
      e_lat = 2 + n + wait_cycles * (1 + n);
      launch(pc0);
      wait_valid(1'b1, 1'b1, cyc);
      n_checks++; if (cyc !== e_lat) begin n_fail++; $display("FAIL rnd_lat[%0d]: got %0d expected %0d", t, cyc, e_lat); end
      n_checks++; if (opcode_o !== e_op) begin n_fail++; $display("FAIL rnd_op[%0d]: got %h expected %h", t, opcode_o, e_op); end
      n_checks++; if (operand_o !== e_opnd) begin n_fail++; $display("FAIL rnd_opnd[%0d]: got %h expected %h", t, operand_o, e_opnd); end
      n_checks++; if (pc_o !== e_pc) begin n_fail++; $display("FAIL rnd_pc[%0d]: got %h expected %h", t, pc_o, e_pc); end
      finish_instr();
    end
    wait_cycles = 0;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    for (int i = 0; i < 256; i++) cnt_tab[i] = 2'd0;
    test_reset();
    test_basic();
    test_wait_states();
    test_stall();
    test_wrap();
    test_reset_midfetch();
    test_overflow_cnt();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time limit so a stuck design cannot hang the run.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, failures so far %0d", n_fail);
    $fatal(1, "time limit");
  end

endmodule
